// File: rtl/i2s_seq_pkg.sv
// +--------------------------------------------------------------------------+
// | i2s_seq_pkg                                                              |
// | Shared state encoding and default sizing for the I2S frame sequencer.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package i2s_seq_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_SEND_L     = 2'd2,
    ST_SEND_R     = 2'd3
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/i2s_seq_pair_fifo.sv
// +--------------------------------------------------------------------------+
// | i2s_seq_pair_fifo                                                        |
// | Show-ahead synchronous FIFO holding packed stereo pairs.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module i2s_seq_pair_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_level = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_wr_en = i_push & ~o_full;
  assign w_rd_en = i_pop & ~o_empty;

  // Storage carries no reset; the count alone defines what is valid.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2s_frame_sequencer.sv
// +--------------------------------------------------------------------------+
// | i2s_frame_sequencer                                                      |
// | Buffers host stereo pairs and issues left/right load strobes to an I2S   |
// | transmitter on each word-select falling edge.                            |
// | Option: define I2S_SEQ_UNDERRUN_CNT_EN to add o_underrun_cnt.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module i2s_frame_sequencer
  import i2s_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                        i_sys_clk,
  input  logic                        i_sys_rst,
  input  logic                        i_enable,
  input  logic [DATA_WIDTH-1:0]       i_pair_left,
  input  logic [DATA_WIDTH-1:0]       i_pair_right,
  input  logic                        i_pair_vld,
  output logic                        o_pair_rdy,
  input  logic                        i_ws,
  output logic [DATA_WIDTH-1:0]       o_left_data,
  output logic [DATA_WIDTH-1:0]       o_right_data,
  output logic                        o_left_vld,
  output logic                        o_right_vld,
  output logic                        o_underrun,
  output logic [$clog2(FIFO_DEPTH):0] o_level
`ifdef I2S_SEQ_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                 o_underrun_cnt
`endif
);

  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int PAIR_W = 2 * DATA_WIDTH;

  seq_state_t              r_state;
  seq_state_t              w_state_next;
  logic                    r_ws_q;
  logic                    w_frame_start;
  logic                    r_pair_rdy;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_left_vld;
  logic                    w_right_vld;
  logic                    w_underrun;
  logic [PAIR_W-1:0]       w_head;
  logic                    w_full;
  logic                    w_empty;
  logic [LVL_W-1:0]        w_level;
  logic [LVL_W-1:0]        w_level_next;
  logic [DATA_WIDTH-1:0]   w_left_sample;
  logic [DATA_WIDTH-1:0]   w_right_sample;
  logic [DATA_WIDTH-1:0]   r_left_data;
  logic [DATA_WIDTH-1:0]   r_right_data;

  i2s_seq_pair_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_pair_fifo (
    .i_clk   (i_sys_clk),
    .i_rst_n (i_sys_rst),
    .i_push  (w_push),
    .i_wdata ({i_pair_left, i_pair_right}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign w_push        = i_pair_vld & r_pair_rdy;
  assign w_frame_start = r_ws_q & ~i_ws;
  assign w_level_next  = w_level + LVL_W'(w_push) - LVL_W'(w_pop);

  assign w_left_sample  = w_empty ? '0 : w_head[PAIR_W-1:DATA_WIDTH];
  assign w_right_sample = w_empty ? '0 : w_head[DATA_WIDTH-1:0];

  assign o_pair_rdy   = r_pair_rdy;
  assign o_level      = w_level;
  assign o_left_vld   = w_left_vld;
  assign o_right_vld  = w_right_vld;
  assign o_underrun   = w_underrun;
  assign o_left_data  = w_left_vld ? w_left_sample : r_left_data;
  assign o_right_data = r_right_data;

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_state <= ST_IDLE;
      r_ws_q  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_ws_q  <= i_ws;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_left_vld   = 1'b0;
    w_right_vld  = 1'b0;
    w_underrun   = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_enable) begin
          w_state_next = ST_WAIT_FRAME;
        end
      end
      ST_WAIT_FRAME: begin
        if (!i_enable) begin
          w_state_next = ST_IDLE;
        end else if (w_frame_start) begin
          w_state_next = ST_SEND_L;
        end
      end
      ST_SEND_L: begin
        w_left_vld   = 1'b1;
        w_underrun   = w_empty;
        w_pop        = ~w_empty;
        w_state_next = ST_SEND_R;
      end
      ST_SEND_R: begin
        w_right_vld  = 1'b1;
        w_state_next = i_enable ? ST_WAIT_FRAME : ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Both halves latch in SEND_L; the right half becomes visible with its
  // strobe one cycle later and both then hold until the next frame.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_left_data  <= '0;
      r_right_data <= '0;
    end else if (w_left_vld) begin
      r_left_data  <= w_left_sample;
      r_right_data <= w_right_sample;
    end
  end

  // Registered ready lets the output read 0 while reset is held and
  // otherwise track not-full of the post-update level.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_pair_rdy <= 1'b0;
    end else begin
      r_pair_rdy <= (w_level_next != LVL_W'(FIFO_DEPTH));
    end
  end

`ifdef I2S_SEQ_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_cnt;

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_underrun_cnt <= '0;
    end else if (w_underrun && (r_underrun_cnt != 16'hFFFF)) begin
      r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign o_underrun_cnt = r_underrun_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_i2s_frame_sequencer.sv
// +--------------------------------------------------------------------------+
// | tb_i2s_frame_sequencer                                                   |
// | Self-checking bench for i2s_frame_sequencer (16-bit samples, depth 4).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_i2s_frame_sequencer;

  logic        sys_clk_tb;
  logic        sys_rst_tb;
  logic        enable;
  logic [15:0] pair_left;
  logic [15:0] pair_right;
  logic        pair_vld;
  logic        pair_rdy;
  logic        ws;
  logic [15:0] left_data;
  logic [15:0] right_data;
  logic        left_vld;
  logic        right_vld;
  logic        underrun;
  logic [2:0]  level;
`ifdef I2S_SEQ_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  i2s_frame_sequencer #(
    .DATA_WIDTH (16),
    .FIFO_DEPTH (4)
  ) dut (
    .i_sys_clk    (sys_clk_tb),
    .i_sys_rst    (sys_rst_tb),
    .i_enable     (enable),
    .i_pair_left  (pair_left),
    .i_pair_right (pair_right),
    .i_pair_vld   (pair_vld),
    .o_pair_rdy   (pair_rdy),
    .i_ws         (ws),
    .o_left_data  (left_data),
    .o_right_data (right_data),
    .o_left_vld   (left_vld),
    .o_right_vld  (right_vld),
    .o_underrun   (underrun),
    .o_level      (level)
`ifdef I2S_SEQ_UNDERRUN_CNT_EN
    ,
    .o_underrun_cnt (underrun_cnt)
`endif
  );

  initial sys_clk_tb = 1'b0;
  always #5 sys_clk_tb = ~sys_clk_tb;

  // {left_vld, right_vld, underrun, rdy, level[2:0], left[15:0], right[15:0]}
  logic [38:0] act_bus;
  assign act_bus = {left_vld, right_vld, underrun, pair_rdy, level, left_data, right_data};

  function automatic logic [38:0] pack(input bit lv, input bit rv, input bit ur, input bit rdy,
                                       input int lvl, input logic [15:0] ld, input logic [15:0] rd);
    return {lv, rv, ur, rdy, 3'(lvl), ld, rd};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input bit vld, input logic [15:0] l, input logic [15:0] r,
                        input bit w, input bit en);
    pair_vld   = vld;
    pair_left  = l;
    pair_right = r;
    ws         = w;
    enable     = en;
  endtask

  // ---------------- reference model: frames as scheduled events ----------
  logic [31:0] mq[$];
  int          frame_phase;   // 0 none, 1 left strobe due, 2 right strobe due
  bit          armed;
  bit          ws_prev;
  bit          fresh;         // no clock edge since reset release
  logic [15:0] held_l;
  logic [15:0] held_r;
  int          ur_count;

  function automatic void model_reset();
    mq.delete();
    frame_phase = 0;
    armed       = 1'b0;
    ws_prev     = 1'b1;
    fresh       = 1'b1;
    held_l      = '0;
    held_r      = '0;
    ur_count    = 0;
  endfunction

  function automatic bit model_rdy();
    return !fresh && (mq.size() < 4);
  endfunction

  function automatic logic [38:0] model_expect();
    bit          due_l;
    logic [15:0] ld;
    due_l = (frame_phase == 1);
    ld    = held_l;
    if (due_l) ld = (mq.size() > 0) ? mq[0][31:16] : 16'h0000;
    return pack(due_l, frame_phase == 2, due_l && mq.size() == 0, model_rdy(),
                mq.size(), ld, held_r);
  endfunction

  function automatic void model_advance(input bit vld, input logic [15:0] l, input logic [15:0] r,
                                        input bit w, input bit en);
    bit          rdy;
    logic [31:0] pr;
    rdy = model_rdy();
    if (frame_phase == 1) begin
      if (mq.size() > 0) begin
        pr     = mq.pop_front();
        held_l = pr[31:16];
        held_r = pr[15:0];
      end else begin
        held_l = '0;
        held_r = '0;
        if (ur_count < 65535) ur_count++;
      end
    end
    if (vld && rdy) mq.push_back({l, r});
    if (frame_phase == 1) begin
      frame_phase = 2;
    end else if (frame_phase == 2) begin
      frame_phase = 0;
      armed       = en;
    end else if (armed) begin
      if (!en) armed = 1'b0;
      else if (ws_prev && !w) frame_phase = 1;
    end else if (en) begin
      armed = 1'b1;
    end
    ws_prev = w;
    fresh   = 1'b0;
  endfunction

  // One clock cycle: starts and ends on a falling edge.
  task automatic mstep(input bit vld, input logic [15:0] l, input logic [15:0] r,
                       input bit w, input bit en);
    check("cycle_outputs", 64'(act_bus), 64'(model_expect()));
`ifdef I2S_SEQ_UNDERRUN_CNT_EN
    check("underrun_cnt", 64'(underrun_cnt), 64'(ur_count));
`endif
    set_in(vld, l, r, w, en);
    @(posedge sys_clk_tb);
    model_advance(vld, l, r, w, en);
    @(negedge sys_clk_tb);
  endtask

  task automatic frame_ws(input bit en);
    mstep(1'b0, 16'h0, 16'h0, 1'b1, en);
    mstep(1'b0, 16'h0, 16'h0, 1'b0, en);
    mstep(1'b0, 16'h0, 16'h0, 1'b0, en);
    mstep(1'b0, 16'h0, 16'h0, 1'b0, en);
  endtask

  task automatic do_reset();
    @(negedge sys_clk_tb);
    sys_rst_tb = 1'b0;
    set_in(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    repeat (2) @(negedge sys_clk_tb);
    check("reset_state", 64'(act_bus), 64'(pack(0, 0, 0, 0, 0, 16'h0, 16'h0)));
    sys_rst_tb = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit          vld;
    logic [15:0] l;
    logic [15:0] r;
    bit          ws;
    bit          en;
    logic [38:0] exp;
  } vec_t;

  function automatic vec_t mkv(input bit vld, input logic [15:0] l, input logic [15:0] r,
                               input bit w, input bit en, input logic [38:0] exp);
    vec_t v;
    v.vld = vld; v.l = l; v.r = r; v.ws = w; v.en = en; v.exp = exp;
    return v;
  endfunction

  vec_t tbl[12];

  initial begin
    int accepted;
    int guard;
    bit wsr;

    sys_rst_tb = 1'b1;
    set_in(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    // Single pair then an empty-FIFO frame; each row lists the outputs seen
    // during that cycle, before its inputs take effect.
    tbl[0]  = mkv(0, 16'h0,    16'h0,    1, 0, pack(0, 0, 0, 0, 0, 16'h0000, 16'h0000));
    tbl[1]  = mkv(1, 16'h1234, 16'hABCD, 1, 1, pack(0, 0, 0, 1, 0, 16'h0000, 16'h0000));
    tbl[2]  = mkv(0, 16'h0,    16'h0,    1, 1, pack(0, 0, 0, 1, 1, 16'h0000, 16'h0000));
    tbl[3]  = mkv(0, 16'h0,    16'h0,    0, 1, pack(0, 0, 0, 1, 1, 16'h0000, 16'h0000));
    tbl[4]  = mkv(0, 16'h0,    16'h0,    0, 1, pack(1, 0, 0, 1, 1, 16'h1234, 16'h0000));
    tbl[5]  = mkv(0, 16'h0,    16'h0,    1, 1, pack(0, 1, 0, 1, 0, 16'h1234, 16'hABCD));
    tbl[6]  = mkv(0, 16'h0,    16'h0,    1, 1, pack(0, 0, 0, 1, 0, 16'h1234, 16'hABCD));
    tbl[7]  = mkv(0, 16'h0,    16'h0,    0, 1, pack(0, 0, 0, 1, 0, 16'h1234, 16'hABCD));
    tbl[8]  = mkv(0, 16'h0,    16'h0,    0, 1, pack(1, 0, 1, 1, 0, 16'h0000, 16'hABCD));
    tbl[9]  = mkv(0, 16'h0,    16'h0,    1, 1, pack(0, 1, 0, 1, 0, 16'h0000, 16'h0000));
    tbl[10] = mkv(0, 16'h0,    16'h0,    1, 1, pack(0, 0, 0, 1, 0, 16'h0000, 16'h0000));
    tbl[11] = mkv(0, 16'h0,    16'h0,    1, 1, pack(0, 0, 0, 1, 0, 16'h0000, 16'h0000));

    do_reset();
    for (int i = 0; i < 12; i++) begin
      check($sformatf("table_row%0d", i), 64'(act_bus), 64'(tbl[i].exp));
      set_in(tbl[i].vld, tbl[i].l, tbl[i].r, tbl[i].ws, tbl[i].en);
      @(negedge sys_clk_tb);
    end
`ifdef I2S_SEQ_UNDERRUN_CNT_EN
    check("underrun_cnt_after_one", 64'(underrun_cnt), 64'd1);
`endif

    // Fill to full, hold the fifth pair until a frame makes room.
    do_reset();
    mstep(1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) mstep(1'b1, 16'h1100 + 16'(k), 16'h2200 + 16'(k), 1'b1, 1'b1);
    check("rdy_when_full", 64'(pair_rdy), 64'd0);
    check("level_when_full", 64'(level), 64'd4);
    mstep(1'b1, 16'h1104, 16'h2204, 1'b1, 1'b1);
    mstep(1'b1, 16'h1104, 16'h2204, 1'b0, 1'b1);
    accepted = 0;
    guard    = 0;
    while (!accepted && guard < 10) begin
      accepted = model_rdy();
      mstep(1'b1, 16'h1104, 16'h2204, 1'b0, 1'b1);
      guard++;
    end
    if (!accepted) check("fifth_push_timeout", 64'd0, 64'd1);
    repeat (6) frame_ws(1'b1);

    // Enable dropped during SEND_L: right strobe still issued, then idle.
    do_reset();
    mstep(1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
    mstep(1'b1, 16'h5A5A, 16'hC3C3, 1'b1, 1'b1);
    mstep(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    check("left_vld_before_disable", 64'(left_vld), 64'd1);
    mstep(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    check("right_vld_after_disable", 64'(right_vld), 64'd1);
    repeat (3) frame_ws(1'b0);

    // Reset asserted mid SEND_L.
    do_reset();
    mstep(1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
    mstep(1'b1, 16'h0F0F, 16'hF0F0, 1'b1, 1'b1);
    mstep(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    check("in_send_l", 64'(left_vld), 64'd1);
    #2 sys_rst_tb = 1'b0;
    #1 check("async_reset_clear", 64'({left_vld, right_vld, underrun, level}), 64'd0);
    @(negedge sys_clk_tb);
    sys_rst_tb = 1'b1;
    model_reset();
    repeat (4) mstep(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    frame_ws(1'b1);

    // Randomised traffic.
    do_reset();
    wsr = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) wsr = ~wsr;
      mstep(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), wsr,
            $urandom_range(0, 9) != 0);
    end

`ifdef I2S_SEQ_UNDERRUN_CNT_EN
    // Counter saturation.
    do_reset();
    mstep(1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
    for (int f = 0; f < 32'h10005; f++) frame_ws(1'b1);
    check("underrun_cnt_saturated", 64'(underrun_cnt), 64'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2s_frame_sequencer.md
I2S_FRAME_SEQUENCER -- requirements
Module: i2s_frame_sequencer

Interface
REQ-001 The block SHALL provide parameter DATA_WIDTH, default 16: width of each channel sample.
REQ-002 The block SHALL provide parameter FIFO_DEPTH, default 4: stereo pairs buffered; power of two, at least 2.
REQ-003 The block SHALL provide port i_sys_clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-004 The block SHALL provide port i_sys_rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL provide port i_enable, input, 1 bit: sequencing enable.
REQ-006 The block SHALL provide ports i_pair_left and i_pair_right, inputs, DATA_WIDTH each: host stereo pair.
REQ-007 The block SHALL provide port i_pair_vld, input, 1 bit; and port o_pair_rdy, output, 1 bit: host push handshake.
REQ-008 The block SHALL provide port i_ws, input, 1 bit: word select from the I2S transmitter, synchronous to i_sys_clk.
REQ-009 The block SHALL provide ports o_left_data and o_right_data, outputs, DATA_WIDTH each: samples to the transmitter.
REQ-010 The block SHALL provide ports o_left_vld and o_right_vld, outputs, 1 bit each: single-cycle load strobes to the transmitter.
REQ-011 The block SHALL provide port o_underrun, output, 1 bit: single-cycle pulse when a frame starts with the FIFO empty.
REQ-012 The block SHALL provide port o_level, output, clog2(FIFO_DEPTH)+1 bits: current pair count.

Function
REQ-013 A push SHALL occur on a cycle with i_pair_vld=1 and o_pair_rdy=1; o_pair_rdy SHALL equal !full, from registered state only.
REQ-014 The FSM SHALL have states IDLE, WAIT_FRAME, SEND_L and SEND_R.
REQ-015 The FSM SHALL transition IDLE->WAIT_FRAME when i_enable=1, and WAIT_FRAME->IDLE when i_enable=0.
REQ-016 A frame start SHALL be detected in cycle N when ws_q=1 and i_ws=0 (registered falling edge); WAIT_FRAME SHALL go to SEND_L in cycle N+1.
REQ-017 SEND_L SHALL last exactly one cycle: o_left_vld=1; o_left_data=popped left sample; the pop occurs this cycle.
REQ-018 SEND_R SHALL last exactly one cycle (N+2): o_right_vld=1; o_right_data=right sample of the same pair.
REQ-019 After SEND_R, the FSM SHALL go to WAIT_FRAME if i_enable=1, else to IDLE; i_enable=0 SHALL never abort a frame in progress.
REQ-020 Data outputs SHALL hold their last value between strobes.
REQ-021 Underrun: if the FIFO is empty on entering SEND_L, both samples SHALL be zero, the strobes SHALL still fire, o_underrun SHALL pulse in the SEND_L cycle, and no pop occurs.
REQ-022 A push in the same cycle as a pop SHALL be accepted when not full; o_level SHALL be unchanged.
REQ-023 ws falling edges in IDLE, SEND_L or SEND_R SHALL be ignored and SHALL cause no underrun.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-025 With i_sys_rst=0, the block SHALL asynchronously set: state IDLE; FIFO empty; ws_q=1; all outputs 0.
REQ-026 Reset mid-frame SHALL clear immediately, with no pending strobe after release.

Configuration
REQ-027 With macro I2S_SEQ_UNDERRUN_CNT_EN defined, output o_underrun_cnt (16 bits) SHALL count underrun pulses, saturate at 0xFFFF, and reset to 0.
REQ-028 Without I2S_SEQ_UNDERRUN_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 Package i2s_seq_pkg SHALL hold the FSM state encoding and the default DATA_WIDTH/FIFO_DEPTH constants.
REQ-030 The pair buffer SHALL be sub-module i2s_seq_pair_fifo: a synchronous FIFO of width 2*DATA_WIDTH, with full/empty/level outputs.

Verification
REQ-031 The bench SHALL cover: push pair (0x1234, 0xABCD), enable, ws 1->0 in cycle N -> o_left_vld=1 with 0x1234 at N+1, o_right_vld=1 with 0xABCD at N+2, o_level 1->0.
REQ-032 The bench SHALL cover: no pushes, enable, one ws falling edge -> both strobes with data 0x0000, o_underrun single pulse, counter=1 (macro on).
REQ-033 The bench SHALL cover: push 5 pairs with FIFO_DEPTH=4 -> o_pair_rdy=0 after 4th, 5th held until a frame pops, then accepted; order preserved across pointer wrap.
REQ-034 The bench SHALL cover: i_enable=0 asserted in the SEND_L cycle -> SEND_R still issued, then IDLE; later ws edges produce no strobes and no underrun.
REQ-035 The bench SHALL cover: i_sys_rst=0 during SEND_L -> o_left_vld and o_right_vld go 0 immediately, o_level=0, no strobe after release until next enabled ws edge.
REQ-036 The bench SHALL cover: 0x10005 underrun frames with macro on -> o_underrun_cnt=0xFFFF.
